// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and byte codes for the UART debug command receiver
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_WR_EXEC  = 3'd3,
        ST_RD_REQ   = 3'd4,
        ST_RD_WAIT  = 3'd5,
        ST_SEND     = 3'd6
    } state_e;

    localparam logic [7:0] CMD_W    = 8'h57;
    localparam logic [7:0] CMD_R    = 8'h52;
    localparam logic [7:0] CMD_P    = 8'h50;

    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_PING = 8'h41;
    localparam logic [7:0] RSP_BAD  = 8'h3F;
    localparam logic [7:0] RSP_TMO  = 8'h45;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - framed debug command decoder between UART byte FIFOs and an 8-bit register bus
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-low reset
//   i_rdata, i_rready, o_rreq    show-ahead RX byte FIFO; pop when o_rreq & i_rready
//   o_wdata, o_wvalid, i_wready  TX response byte handshake
//   o_reg_addr, o_reg_wdata      register bus address / write data
//   o_reg_we, o_reg_re           one-cycle write / read strobes
//   i_reg_rdata, i_reg_rvalid    register read return
//   o_busy                       high whenever not idle
//   o_err_cnt                    saturating count of aborted or invalid frames
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 1_000_000,
    parameter int RD_TIMEOUT   = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rdata,
    input  logic       i_rready,
    output logic       o_rreq,
    output logic [7:0] o_wdata,
    input  logic       i_wready,
    output logic       o_wvalid,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    output logic       o_reg_re,
    input  logic [7:0] i_reg_rdata,
    input  logic       i_reg_rvalid,
    output logic       o_busy,
    output logic [7:0] o_err_cnt
);

    localparam int TMO_MAX = max_int(BYTE_TIMEOUT, RD_TIMEOUT);
    localparam int TMO_W   = $clog2(TMO_MAX + 1);
    localparam logic [TMO_W-1:0] BYTE_LIM = TMO_W'(BYTE_TIMEOUT);
    localparam logic [TMO_W-1:0] RD_LIM   = TMO_W'(RD_TIMEOUT);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             is_wr_q, is_wr_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rsp_q, rsp_d;
    logic [7:0]       err_q, err_d;
    logic             err_inc;
    logic             pop;

    // Popping is gated by reset so no byte is lost while the block is held in reset.
    assign pop = i_rst && i_rready &&
                 (state_q == ST_IDLE || state_q == ST_GET_ADDR || state_q == ST_GET_DATA);

    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rsp_d   = rsp_q;
        err_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    case (i_rdata)
                        CMD_W: begin
                            is_wr_d = 1'b1;
                            state_d = ST_GET_ADDR;
                        end
                        CMD_R: begin
                            is_wr_d = 1'b0;
                            state_d = ST_GET_ADDR;
                        end
                        CMD_P: begin
                            rsp_d   = RSP_PING;
                            state_d = ST_SEND;
                        end
                        default: begin
                            rsp_d   = RSP_BAD;
                            err_inc = 1'b1;
                            state_d = ST_SEND;
                        end
                    endcase
                end
            end
            ST_GET_ADDR: begin
                if (pop) begin
                    addr_d  = i_rdata;
                    state_d = is_wr_q ? ST_GET_DATA : ST_RD_REQ;
                end else if (cnt_q == BYTE_LIM) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (pop) begin
                    wdata_d = i_rdata;
                    state_d = ST_WR_EXEC;
                end else if (cnt_q == BYTE_LIM) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WR_EXEC: begin
                rsp_d   = RSP_OK;
                state_d = ST_SEND;
            end
            ST_RD_REQ: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // Late data arriving exactly at expiry is still delivered.
                if (i_reg_rvalid) begin
                    rsp_d   = i_reg_rdata;
                    state_d = ST_SEND;
                end else if (cnt_q == RD_LIM) begin
                    rsp_d   = RSP_TMO;
                    err_inc = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_wready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The counter only runs in states that can time out; it restarts on any pop or move.
        if (pop || state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_GET_ADDR || state_q == ST_GET_DATA || state_q == ST_RD_WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rsp_q   <= 8'h00;
            err_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
        end
    end

    assign o_rreq      = pop;
    assign o_wdata     = rsp_q;
    assign o_wvalid    = (state_q == ST_SEND);
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_we    = (state_q == ST_WR_EXEC);
    assign o_reg_re    = (state_q == ST_RD_REQ);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_err_cnt   = err_q;

endmodule
